// File: rtl/ir_tx_pkg.sv
// Shared types and elaboration-time helpers for the IR frame transmitter.
package ir_tx_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, SEG0, CONN, SEG1, STOP, GAP} state_t;

  function automatic int unsigned cyc(int unsigned clk_hz, int unsigned us);
    return (clk_hz / 1000000) * us;
  endfunction

  // Bits needed to hold values 0..maxval (never less than one).
  function automatic int cw(int unsigned maxval);
    return (maxval < 2) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/ir_frame_tx_carrier.sv
// Carrier source: P-cycle phase counter, high for the first P/2 cycles of each period.
module ir_carrier_gen
  import ir_tx_pkg::*;
#(
  parameter int unsigned PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic carrier
);

  localparam int PW = cw(PERIOD - 1);

  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 phase <= '0;
    else if (clr || phase == PW'(PERIOD - 1)) phase <= '0;
    else                                      phase <= phase + PW'(1);
  end

  assign carrier = (phase < PW'(PERIOD / 2));

endmodule

// File: rtl/ir_frame_tx.sv
// IR frame transmitter: leader, segment 0, connect code, segment 1, stop mark,
// optionally repeated with an inter-frame gap.
module ir_frame_tx
  import ir_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 125000000,
  parameter int unsigned CARRIER_HZ      = 38000,
  parameter int unsigned SEG0_BITS       = 35,
  parameter int unsigned SEG1_BITS       = 32,
  parameter bit          LSB_FIRST       = 1'b0,
  parameter bit          OUT_ACTIVE_HIGH = 1'b1,
  parameter int unsigned T_LEAD_MARK_US  = 9000,
  parameter int unsigned T_LEAD_SPACE_US = 4500,
  parameter int unsigned T_BIT_MARK_US   = 560,
  parameter int unsigned T_ZERO_SPACE_US = 560,
  parameter int unsigned T_ONE_SPACE_US  = 1690,
  parameter int unsigned T_CONN_SPACE_US = 20000,
  parameter int unsigned T_GAP_US        = 40000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [SEG0_BITS-1:0] seg0_data,
  input  logic [SEG1_BITS-1:0] seg1_data,
  input  logic [3:0]           repeat_cnt,
  input  logic                 abort,
  output logic                 ir_out,
  output logic                 envelope,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  function automatic int unsigned umax(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned C_LM  = cyc(CLK_HZ, T_LEAD_MARK_US);
  localparam int unsigned C_LS  = cyc(CLK_HZ, T_LEAD_SPACE_US);
  localparam int unsigned C_BM  = cyc(CLK_HZ, T_BIT_MARK_US);
  localparam int unsigned C_ZS  = cyc(CLK_HZ, T_ZERO_SPACE_US);
  localparam int unsigned C_OS  = cyc(CLK_HZ, T_ONE_SPACE_US);
  localparam int unsigned C_CS  = cyc(CLK_HZ, T_CONN_SPACE_US);
  localparam int unsigned C_GP  = cyc(CLK_HZ, T_GAP_US);
  localparam int unsigned C_MAX = umax(umax(umax(C_LM, C_LS), umax(C_BM, C_ZS)),
                                       umax(umax(C_OS, C_CS), C_GP));
  localparam int CW = cw(C_MAX);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CW-1:0] N_LM = CW'(C_LM - 1);
  localparam logic [CW-1:0] N_LS = CW'(C_LS - 1);
  localparam logic [CW-1:0] N_BM = CW'(C_BM - 1);
  localparam logic [CW-1:0] N_ZS = CW'(C_ZS - 1);
  localparam logic [CW-1:0] N_OS = CW'(C_OS - 1);
  localparam logic [CW-1:0] N_CS = CW'(C_CS - 1);
  localparam logic [CW-1:0] N_GP = CW'(C_GP - 1);

  localparam logic [5:0] B0_FIRST = LSB_FIRST ? 6'd0 : 6'(SEG0_BITS - 1);
  localparam logic [5:0] B0_LAST  = LSB_FIRST ? 6'(SEG0_BITS - 1) : 6'd0;
  localparam logic [5:0] B1_FIRST = LSB_FIRST ? 6'd0 : 6'(SEG1_BITS - 1);
  localparam logic [5:0] B1_LAST  = LSB_FIRST ? 6'(SEG1_BITS - 1) : 6'd0;

  state_t          state, state_n;
  logic            mark_n, done_n, aborted_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [5:0]      bidx, bidx_n, bstep;
  logic [3:0]      rep, rep_n;
  logic [63:0]     s0, s1;
  logic            accept, cur_bit, last_bit, carrier, clr;

  assign start_ready = (state == IDLE) && !done;
  assign busy        = (state != IDLE);
  assign accept      = start_valid && start_ready;
  assign cur_bit     = (state == SEG0) ? s0[bidx] : s1[bidx];
  assign last_bit    = (state == SEG0) ? (bidx == B0_LAST) : (bidx == B1_LAST);
  assign bstep       = LSB_FIRST ? bidx + 6'd1 : bidx - 6'd1;
  // Carrier realigns at the start of every frame (first accept and after each gap).
  assign clr         = (state_n == LEAD) && (state != LEAD);

  always_comb begin
    state_n   = state;
    mark_n    = envelope;
    cnt_n     = cnt;
    bidx_n    = bidx;
    rep_n     = rep;
    done_n    = 1'b0;
    aborted_n = 1'b0;
    if (state == IDLE) begin
      if (accept) begin
        state_n = LEAD; mark_n = 1'b1; cnt_n = N_LM; rep_n = repeat_cnt;
      end
    end else if (abort) begin
      state_n = IDLE; mark_n = 1'b0; aborted_n = 1'b1;
    end else if (cnt != '0) begin
      cnt_n = cnt - CW'(1);
    end else begin
      case (state)
        LEAD:
          if (envelope) begin mark_n = 1'b0; cnt_n = N_LS; end
          else begin state_n = SEG0; mark_n = 1'b1; cnt_n = N_BM; bidx_n = B0_FIRST; end
        SEG0, SEG1:
          if (envelope) begin
            mark_n = 1'b0; cnt_n = cur_bit ? N_OS : N_ZS;
          end else begin
            mark_n = 1'b1; cnt_n = N_BM;
            if (!last_bit)          bidx_n  = bstep;
            else if (state == SEG0) state_n = CONN;
            else                    state_n = STOP;
          end
        CONN:
          if (envelope) begin mark_n = 1'b0; cnt_n = N_CS; end
          else begin state_n = SEG1; mark_n = 1'b1; cnt_n = N_BM; bidx_n = B1_FIRST; end
        STOP: begin
          mark_n = 1'b0;
          if (rep != 4'd0) begin state_n = GAP; cnt_n = N_GP; end
          else begin state_n = IDLE; done_n = 1'b1; end
        end
        GAP: begin
          state_n = LEAD; mark_n = 1'b1; cnt_n = N_LM; rep_n = rep - 4'd1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      envelope <= 1'b0;
      cnt      <= '0;
      bidx     <= '0;
      rep      <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      state    <= state_n;
      envelope <= mark_n;
      cnt      <= cnt_n;
      bidx     <= bidx_n;
      rep      <= rep_n;
      done     <= done_n;
      aborted  <= aborted_n;
    end
  end

  // Payload shadows, zero-extended so any 6-bit index is in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0 <= '0;
      s1 <= '0;
    end else if (accept) begin
      s0 <= 64'(seg0_data);
      s1 <= 64'(seg1_data);
    end
  end

  ir_carrier_gen #(.PERIOD(CLK_HZ / CARRIER_HZ)) u_carrier (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .carrier (carrier)
  );

  assign ir_out = (envelope & carrier) ^ !OUT_ACTIVE_HIGH;

endmodule

// File: tb/tb_ir_frame_tx.sv
// Bench for ir_frame_tx: two instances (MSB-first active-high, LSB-first inverted)
// checked every cycle against a frame-schedule model; timings shortened to keep runs brief.
module tb_ir_frame_tx;

  localparam int P  = 10;
  localparam int LM = 450, LS = 225, BM = 28, ZS = 28, OS = 84, CS = 500, GP = 1000;
  localparam logic [63:0] S0 = 64'h4_0840_1052;
  localparam logic [63:0] S1 = 64'h0040_000C;

  typedef struct packed {
    logic       env, busy, ready, done, abrt;
    logic [3:0] ph;
  } ent_t;

  localparam ent_t IDLE_E = '{env:1'b0, busy:1'b0, ready:1'b1, done:1'b0, abrt:1'b0, ph:4'd0};

  logic        clk, rst;
  logic [1:0]  sv, ab;
  logic [63:0] s0, s1;
  logic [3:0]  rc;
  logic [1:0]  rdy_w, ir_w, env_w, busy_w, done_w, abt_w;

  ent_t q[$];
  ent_t cur;
  bit   tr[$];
  int   cur_d, mph, acc_cnt, vec, miss;
  int   dn[2], ac[2];

  ir_frame_tx #(
    .CLK_HZ(1000000), .CARRIER_HZ(100000), .SEG0_BITS(35), .SEG1_BITS(32),
    .LSB_FIRST(1'b0), .OUT_ACTIVE_HIGH(1'b1),
    .T_LEAD_MARK_US(LM), .T_LEAD_SPACE_US(LS), .T_BIT_MARK_US(BM),
    .T_ZERO_SPACE_US(ZS), .T_ONE_SPACE_US(OS), .T_CONN_SPACE_US(CS), .T_GAP_US(GP)
  ) dut_a (
    .clk(clk), .rst(rst), .start_valid(sv[0]), .start_ready(rdy_w[0]),
    .seg0_data(s0[34:0]), .seg1_data(s1[31:0]), .repeat_cnt(rc), .abort(ab[0]),
    .ir_out(ir_w[0]), .envelope(env_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .aborted(abt_w[0])
  );

  ir_frame_tx #(
    .CLK_HZ(1000000), .CARRIER_HZ(100000), .SEG0_BITS(8), .SEG1_BITS(5),
    .LSB_FIRST(1'b1), .OUT_ACTIVE_HIGH(1'b0),
    .T_LEAD_MARK_US(LM), .T_LEAD_SPACE_US(LS), .T_BIT_MARK_US(BM),
    .T_ZERO_SPACE_US(ZS), .T_ONE_SPACE_US(OS), .T_CONN_SPACE_US(CS), .T_GAP_US(GP)
  ) dut_b (
    .clk(clk), .rst(rst), .start_valid(sv[1]), .start_ready(rdy_w[1]),
    .seg0_data(s0[7:0]), .seg1_data(s1[4:0]), .repeat_cnt(rc), .abort(ab[1]),
    .ir_out(ir_w[1]), .envelope(env_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .aborted(abt_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- frame-schedule model ----------------
  function automatic void add(bit lvl, int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.env = lvl; e.busy = 1'b1; e.ph = 4'(mph % P);
      q.push_back(e);
      mph++;
    end
  endfunction

  function automatic void add_seg(int d, logic [63:0] v, int nb);
    int idx;
    for (int k = 0; k < nb; k++) begin
      idx = (d == 1) ? k : nb - 1 - k;
      add(1'b1, BM);
      add(1'b0, v[idx] ? OS : ZS);
    end
  endfunction

  function automatic void build(int d, logic [63:0] a, logic [63:0] b, int rep);
    ent_t e;
    for (int f = 0; f <= rep; f++) begin
      if (f > 0) add(1'b0, GP);
      mph = 0;
      add(1'b1, LM); add(1'b0, LS);
      add_seg(d, a, (d == 1) ? 8 : 35);
      add(1'b1, BM); add(1'b0, CS);
      add_seg(d, b, (d == 1) ? 5 : 32);
      add(1'b1, BM);
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endfunction

  initial begin
    ent_t e;
    cur = IDLE_E;
    forever begin
      @(posedge clk);
      if (!rst) begin
        q.delete(); cur = IDLE_E;
      end else begin
        if (ab[cur_d] && cur.busy) begin
          q.delete(); e = '0; e.ready = 1'b1; e.abrt = 1'b1; q.push_back(e);
        end else if (sv[cur_d] && cur.ready) begin
          build(cur_d, s0, s1, int'(rc)); acc_cnt++;
        end
        cur = (q.size() > 0) ? q.pop_front() : IDLE_E;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    ent_t e;
    logic ir_e;
    logic [5:0] got, exp;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        e    = (d == cur_d) ? cur : IDLE_E;
        ir_e = (e.env && (e.ph < 4'(P / 2))) ^ (d == 1);
        exp  = {ir_e, e.env, e.busy, e.ready, e.done, e.abrt};
        got  = {ir_w[d], env_w[d], busy_w[d], rdy_w[d], done_w[d], abt_w[d]};
        vec++;
        if (got !== exp) begin
          miss++;
          if (miss <= 20)
            $display("FAIL cycle dut=%0d t=%0t ir/env/busy/ready/done/aborted got=%b required=%b",
                     d, $time, got, exp);
        end
        if (done_w[d]) dn[d]++;
        if (abt_w[d])  ac[d]++;
      end
      if (busy_w[cur_d]) tr.push_back(env_w[cur_d]);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(string nm, int got, int exp);
    vec++;
    if (got != exp) begin
      miss++;
      $display("FAIL %s got=%0d required=%0d", nm, got, exp);
    end
  endtask

  function automatic int run_len(int k);
    int r = 0, n = 0;
    for (int i = 0; i < tr.size(); i++) begin
      if (i > 0 && tr[i] != tr[i-1]) r++;
      if (r == k) n++;
      else if (r > k) break;
    end
    return n;
  endfunction

  // Holds start_valid until the model reports an accept, then scrambles the
  // payload inputs to show they are ignored while busy.
  task automatic start(int d, logic [63:0] a, logic [63:0] b, logic [3:0] r);
    int base, n;
    base = acc_cnt; n = 0;
    cur_d = d; s0 = a; s1 = b; rc = r; sv[d] = 1'b1;
    while (acc_cnt == base && n < 30000) begin @(posedge clk); #1; n++; end
    sv[d] = 1'b0;
    chk("accept_seen", acc_cnt - base, 1);
    s0 = {$urandom, $urandom}; s1 = {$urandom, $urandom}; rc = 4'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || cur.busy || cur.done || cur.abrt) && n < 30000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 30000) chk("idle_timeout", n, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sv = '0; ab = '0; s0 = '0; s1 = '0; rc = '0; cur_d = 0; rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("idle_ir", int'(ir_w[0]), 0);
    chk("idle_ready", int'(rdy_w[0]), 1);
    chk("idle_busy", int'(busy_w[0]), 0);
    chk("idle_done", dn[0], 0);
    chk("idle_ir_inverted", int'(ir_w[1]), 1);

    ab[0] = 1'b1; @(posedge clk); #1 ab[0] = 1'b0;
    @(posedge clk); #1;
    chk("idle_abort_ignored", ac[0], 0);

    // single MSB-first frame
    tr.delete();
    start(0, S0, S1, 4'd0);
    wait_idle();
    chk("frame_len", tr.size(), 5543);
    chk("lead_mark", run_len(0), 450);
    chk("lead_space", run_len(1), 225);
    chk("bit34_mark", run_len(2), 28);
    chk("bit34_space", run_len(3), 84);
    chk("bit33_space", run_len(5), 28);
    chk("conn_space", run_len(73), 500);
    chk("done_single", dn[0], 1);

    // three frames; next request held through the done cycle
    tr.delete();
    start(0, S0, S1, 4'd2);
    start(0, {$urandom, $urandom}, {$urandom, $urandom}, 4'd0);
    chk("repeat_len", tr.size(), 18629);
    chk("repeat_gap", run_len(139), 1000);
    chk("repeat_lead2", run_len(140), 450);
    chk("repeat_done", dn[0], 2);
    tr.delete();
    wait_idle();
    chk("random_done", dn[0], 3);

    // abort inside segment 1, then a fresh frame two cycles later
    start(0, S0, S1, 4'd1);
    repeat (4159) @(posedge clk);
    #1 ab[0] = 1'b1;
    @(posedge clk); #1 ab[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_pulse", ac[0], 1);
    chk("abort_no_done", dn[0], 3);
    tr.delete();
    start(0, {$urandom, $urandom}, {$urandom, $urandom}, 4'd0);
    wait_idle();
    chk("after_abort_lead", run_len(0), 450);
    chk("after_abort_done", dn[0], 4);

    // LSB-first, inverted output
    tr.delete();
    start(1, 64'd1, {$urandom, $urandom}, 4'd0);
    wait_idle();
    chk("lsb_first_space", run_len(3), 84);
    chk("lsb_bit1_space", run_len(5), 28);
    chk("b_done", dn[1], 1);
    chk("b_idle_ir", int'(ir_w[1]), 1);

    for (int i = 0; i < 3; i++) begin
      start(1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(10, 2000)) @(posedge clk);
        #1 ab[1] = 1'b1;
        @(posedge clk); #1 ab[1] = 1'b0;
      end
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
